// File: rtl/clk_meas_pkg.sv
// Shared types and constants for the clk_meas period/duty measurement block.
package clk_meas_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } state_t;

  localparam int DUTY_W    = 7;
  localparam int PCT_SCALE = 100;
  localparam int DIV_LAT   = 8;

endpackage

// File: rtl/clk_meas_div.sv
// Restoring divider producing a DUTY_W-bit quotient, one bit per cycle after a load cycle.
// o_done/o_quot are valid during the final iteration so the caller can register them on that edge.
module clk_meas_div
  import clk_meas_pkg::*;
#(
  parameter int DW = 16,
  parameter int NW = DW + DUTY_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [NW-1:0]     i_num,
  input  logic [DW-1:0]     i_den,
  output logic              o_busy,
  output logic              o_done,
  output logic [DUTY_W-1:0] o_quot
);

  localparam logic [2:0] LAST_STEP = 3'(DIV_LAT - 2);

  logic [NW-1:0]       r_rem;
  logic [NW-1:0]       r_dsh;
  logic [DUTY_W-2:0]   r_quot;
  logic [2:0]          r_step;
  logic                r_busy;
  logic                w_ge;

  // Quotient is known to be < 2^DUTY_W because high <= period and PCT_SCALE < 128.
  assign w_ge = (r_rem >= r_dsh);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rem  <= '0;
      r_dsh  <= '0;
      r_quot <= '0;
      r_step <= '0;
      r_busy <= 1'b0;
    end else if (i_abort) begin
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_rem  <= i_num;
      r_dsh  <= NW'(i_den) << (DUTY_W - 1);
      r_quot <= '0;
      r_step <= '0;
    end else if (r_busy) begin
      if (w_ge) r_rem <= r_rem - r_dsh;
      r_dsh  <= r_dsh >> 1;
      r_quot <= {r_quot[DUTY_W-3:0], w_ge};
      r_step <= r_step + 3'd1;
      if (r_step == LAST_STEP) r_busy <= 1'b0;
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_busy && (r_step == LAST_STEP) && !i_abort;
  assign o_quot = {r_quot, w_ge};

endmodule

// File: rtl/clk_meas.sv
// Measures high time and period of an asynchronous signal in i_clk cycles.
// Define CLK_MEAS_DUTY_CALC_EN to add the duty-percentage divider (and overrun reporting).
//
// state     | meaning
// IDLE      | disabled, waiting for i_en
// WAIT_RISE | armed, waiting for the opening rising edge
// MEAS_HIGH | counting the high phase
// MEAS_LOW  | counting the low phase; next rise closes the period
module clk_meas
  import clk_meas_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_sig_in,
  output logic              o_meas_valid,
  output logic [CNT_W-1:0]  o_period_cnt,
  output logic [CNT_W-1:0]  o_high_cnt,
  output logic [DUTY_W-1:0] o_duty_pct,
  output logic              o_timeout,
  output logic              o_overrun,
  output logic              o_busy
);

  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + ONE;
  endfunction

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_hold;
  logic [CNT_W-1:0]       r_idle;
  logic [CNT_W-1:0]       r_period;
  logic [CNT_W-1:0]       r_high;
  logic                   r_valid;
  logic                   r_timeout;
  logic                   w_synced;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_to;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig_in};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_synced = r_sync[SYNC_STAGES-1];
  assign w_rise   = w_synced & ~r_prev;
  assign w_fall   = ~w_synced & r_prev;
  assign w_to     = (r_idle == TO_VAL);

`ifdef CLK_MEAS_DUTY_CALC_EN
  localparam int NUM_W = CNT_W + DUTY_W;

  logic [CNT_W-1:0]  r_pend_period;
  logic [CNT_W-1:0]  r_pend_high;
  logic [DUTY_W-1:0] r_duty;
  logic              r_overrun;
  logic [NUM_W-1:0]  w_num;
  logic              w_div_start;
  logic              w_div_busy;
  logic              w_div_done;
  logic [DUTY_W-1:0] w_div_quot;

  assign w_num       = NUM_W'(r_hold) * NUM_W'(PCT_SCALE);
  assign w_div_start = i_en && (r_state == MEAS_LOW) && w_rise && !w_div_busy;

  clk_meas_div #(.DW(CNT_W)) u_div (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (w_div_start),
    .i_abort (!i_en),
    .i_num   (w_num),
    .i_den   (r_cnt),
    .o_busy  (w_div_busy),
    .o_done  (w_div_done),
    .o_quot  (w_div_quot)
  );

  assign o_duty_pct = r_duty;
  assign o_overrun  = r_overrun;
`else
  assign o_duty_pct = '0;
  assign o_overrun  = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_hold    <= '0;
      r_idle    <= '0;
      r_period  <= '0;
      r_high    <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
`ifdef CLK_MEAS_DUTY_CALC_EN
      r_pend_period <= '0;
      r_pend_high   <= '0;
      r_duty        <= '0;
      r_overrun     <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
`ifdef CLK_MEAS_DUTY_CALC_EN
      r_overrun <= 1'b0;
      if (w_div_done) begin
        r_period <= r_pend_period;
        r_high   <= r_pend_high;
        r_duty   <= w_div_quot;
        r_valid  <= 1'b1;
      end
`endif
      if (!i_en) begin
        r_state   <= IDLE;
        r_timeout <= 1'b0;
        r_cnt     <= '0;
        r_idle    <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= WAIT_RISE;
            r_cnt   <= '0;
            r_idle  <= '0;
          end
          WAIT_RISE: begin
            if (w_rise) begin
              r_cnt   <= ONE;
              r_idle  <= '0;
              r_state <= MEAS_HIGH;
            end else if (w_fall) begin
              r_idle <= '0;
            end else if (w_to) begin
              r_timeout <= 1'b1;
              r_idle    <= '0;
            end else begin
              r_idle <= f_sat_inc(r_idle);
            end
          end
          MEAS_HIGH: begin
            if (w_fall) begin
              r_hold  <= r_cnt;
              r_cnt   <= f_sat_inc(r_cnt);
              r_idle  <= '0;
              r_state <= MEAS_LOW;
            end else if (w_to) begin
              r_timeout <= 1'b1;
              r_idle    <= '0;
              r_cnt     <= '0;
              r_state   <= WAIT_RISE;
            end else begin
              r_cnt  <= f_sat_inc(r_cnt);
              r_idle <= f_sat_inc(r_idle);
            end
          end
          MEAS_LOW: begin
            // A closing rise beats a coincident timeout.
            if (w_rise) begin
`ifdef CLK_MEAS_DUTY_CALC_EN
              if (w_div_busy) begin
                r_overrun <= 1'b1;
              end else begin
                r_pend_period <= r_cnt;
                r_pend_high   <= r_hold;
              end
`else
              r_period <= r_cnt;
              r_high   <= r_hold;
              r_valid  <= 1'b1;
`endif
              r_cnt   <= ONE;
              r_idle  <= '0;
              r_state <= MEAS_HIGH;
            end else if (w_to) begin
              r_timeout <= 1'b1;
              r_idle    <= '0;
              r_cnt     <= '0;
              r_state   <= WAIT_RISE;
            end else begin
              r_cnt  <= f_sat_inc(r_cnt);
              r_idle <= f_sat_inc(r_idle);
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_meas_valid = r_valid;
  assign o_period_cnt = r_period;
  assign o_high_cnt   = r_high;
  assign o_timeout    = r_timeout;
  assign o_busy       = (r_state != IDLE);

endmodule

// File: tb/tb_clk_meas.sv
// Directed bench for clk_meas: table of periodic patterns plus hand-written corner sequences.
module tb_clk_meas;
  import clk_meas_pkg::*;

  localparam int CW = 16;
`ifdef CLK_MEAS_DUTY_CALC_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif
  localparam int LAT = 2 + (FEAT ? DIV_LAT : 1);

  logic          clk = 1'b0;
  logic          rst, en, sig;
  logic          meas_valid, timeout, overrun, busy;
  logic [CW-1:0] period_cnt, high_cnt;
  logic [DUTY_W-1:0] duty_pct;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ovr_cnt = 0;

  typedef struct {int p; int h; int d; int c;} res_t;
  res_t q[$];

  typedef struct {int h; int l; int ep; int eh; int ed;} vec_t;
  vec_t vecs[5];

  clk_meas #(.CNT_W(CW), .SYNC_STAGES(2), .TIMEOUT_CYC(1000)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_en         (en),
    .i_sig_in     (sig),
    .o_meas_valid (meas_valid),
    .o_period_cnt (period_cnt),
    .o_high_cnt   (high_cnt),
    .o_duty_pct   (duty_pct),
    .o_timeout    (timeout),
    .o_overrun    (overrun),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (meas_valid) q.push_back('{int'(period_cnt), int'(high_cnt), int'(duty_pct), cyc});
    if (overrun) ovr_cnt++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_period(input int h, input int l);
    sig = 1'b1;
    repeat (h) @(negedge clk);
    sig = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic restart();
    en  = 1'b0;
    sig = 1'b0;
    repeat (3) @(negedge clk);
    q.delete();
    ovr_cnt = 0;
    en = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_results(input string tag, input int n, input int ep, input int eh, input int ed);
    chk({tag, "_count"}, q.size(), n);
    foreach (q[k]) begin
      chk({tag, "_period"}, q[k].p, ep);
      chk({tag, "_high"}, q[k].h, eh);
      chk({tag, "_duty"}, q[k].d, ed);
    end
  endtask

  initial begin
    int rc, ec, tl;
    vecs[0] = '{3, 7, 10, 3, 30};
    vecs[1] = '{50, 50, 100, 50, 50};
    vecs[2] = '{4, 12, 16, 4, 25};
    vecs[3] = '{1, 9, 10, 1, 10};
    vecs[4] = '{7, 1, 8, 7, 87};

    rst = 1'b1; en = 1'b0; sig = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", meas_valid, 0);
    chk("rst_period", period_cnt, 0);
    chk("rst_high", high_cnt, 0);
    chk("rst_duty", duty_pct, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      restart();
      repeat (4) drive_period(vecs[i].h, vecs[i].l);
      sig = 1'b0;
      repeat (15) @(negedge clk);
      check_results($sformatf("vec%0d", i), 3, vecs[i].ep, vecs[i].eh, FEAT ? vecs[i].ed : 0);
      chk($sformatf("vec%0d_overrun", i), ovr_cnt, 0);
    end

    // Latency from the driven closing rise to meas_valid
    restart();
    drive_period(50, 50);
    sig = 1'b1;
    rc = cyc;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (q.size() > 0) break;
    end
    chk("lat_count", q.size(), 1);
    if (q.size() > 0) begin
      chk("lat_cycles", q[0].c - rc, LAT);
      chk("lat_period", q[0].p, 100);
      chk("lat_high", q[0].h, 50);
      chk("lat_duty", q[0].d, FEAT ? 50 : 0);
    end

    // Period 5: divider cannot keep up with every period
    restart();
    repeat (7) drive_period(2, 3);
    sig = 1'b0;
    repeat (15) @(negedge clk);
    check_results("ovr", FEAT ? 3 : 6, 5, 2, FEAT ? 40 : 0);
    chk("ovr_pulses", ovr_cnt, FEAT ? 3 : 0);

    // Timeout with sig stuck low
    en = 1'b0; sig = 1'b0;
    repeat (3) @(negedge clk);
    q.delete();
    en = 1'b1;
    ec = cyc;
    tl = -1;
    for (int k = 0; k < 1100; k++) begin
      @(negedge clk);
      if (timeout) begin
        tl = cyc - ec;
        break;
      end
    end
    chk("timeout_window", int'(tl >= 1000 && tl <= 1005), 1);
    chk("timeout_busy", busy, 1);
    repeat (100) @(negedge clk);
    chk("timeout_sticky", timeout, 1);
    chk("timeout_no_valid", q.size(), 0);
    en = 1'b0;
    @(negedge clk);
    chk("timeout_clear", timeout, 0);
    chk("timeout_busy_clear", busy, 0);

    // Disable while the closing rise is still in the synchronizer
    restart();
    repeat (2) drive_period(3, 7);
    sig = 1'b1;
    repeat (2) @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    sig = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_count", q.size(), 1);
    chk("abort_hold_period", period_cnt, 10);
    chk("abort_hold_high", high_cnt, 3);
    chk("abort_hold_duty", duty_pct, FEAT ? 30 : 0);
    chk("abort_busy", busy, 0);

    // Re-enable: first result needs a full new period
    q.delete();
    en = 1'b1;
    repeat (3) @(negedge clk);
    drive_period(4, 4);
    chk("reen_first", q.size(), 0);
    repeat (2) drive_period(4, 4);
    sig = 1'b0;
    repeat (15) @(negedge clk);
    check_results("reen", 2, 8, 4, FEAT ? 50 : 0);

    // Asynchronous reset in MEAS_LOW
    sig = 1'b1;
    repeat (4) @(negedge clk);
    sig = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("arst_period", period_cnt, 0);
    chk("arst_high", high_cnt, 0);
    chk("arst_duty", duty_pct, 0);
    chk("arst_busy", busy, 0);
    chk("arst_valid", meas_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    en = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_meas.md
Name: clk_meas

Overview:
- Synthesizable measurement stage placed directly downstream of the bench clock generator.
- Samples an asynchronous periodic input `sig_in` in the `clk` domain.
- Counts the high time and full period of `sig_in` in `clk` cycles and reports them with a one-cycle valid pulse.
- Used to check programmed frequency/duty in simulation and on silicon test clocks.

Parameters:
- CNT_W, 16, width of period/high counters; a count saturates at 2^CNT_W-1.
- SYNC_STAGES, 2, synchronizer flop depth on `sig_in` (min 2).
- TIMEOUT_CYC, 1000, cycles without a `sig_in` edge before timeout; must be < 2^CNT_W-1.

Ports:
- clk  in  1  sampling/reference clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- en  in  1  measurement enable; level sensitive.
- sig_in  in  1  asynchronous signal under measurement.
- meas_valid  out  1  one-cycle pulse: period_cnt/high_cnt/duty_pct hold a new result.
- period_cnt  out  CNT_W  cycles from rising edge to next rising edge.
- high_cnt  out  CNT_W  cycles sig high within that period.
- duty_pct  out  7  floor(high_cnt*100/period_cnt), range 0..100.
- timeout  out  1  sticky: no edge for TIMEOUT_CYC cycles.
- overrun  out  1  one-cycle pulse: a result was dropped.
- busy  out  1  high when state != IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, synchronizer flops 0.
- `sig_in` passes through SYNC_STAGES flops, then one extra flop for edge detect.
  - `rise` = synced & ~prev; `fall` = ~synced & prev.
  - The constant synchronizer latency does not alter counts.
- FSM:
  - IDLE: en=1 -> WAIT_RISE; cnt cleared.
  - WAIT_RISE: ignore `fall`. `rise` -> MEAS_HIGH, cnt<=1.
  - MEAS_HIGH: cnt++ each cycle. `fall` -> hold<=cnt, cnt++, go MEAS_LOW.
  - MEAS_LOW: cnt++. `rise` -> period<=cnt, high<=hold, start result, cnt<=1, go MEAS_HIGH. Measurement is continuous; back-to-back periods are all reported.
- Result: sig high H cycles, low L cycles -> period_cnt=H+L, high_cnt=H.
- Timeout:
  - An idle counter resets on every `rise`/`fall` and on entry to WAIT_RISE.
  - When it reaches TIMEOUT_CYC in WAIT_RISE, MEAS_HIGH or MEAS_LOW: timeout<=1, go WAIT_RISE, partial measurement discarded.
  - timeout stays set until en=0 or rst.
- en=0 in any state: next cycle state IDLE, any in-flight result aborted, no meas_valid, timeout cleared.
- Output registers hold their last result until the next meas_valid. Only one result is in flight at a time.
- Simultaneous `rise` and timeout count: `rise` wins, and the idle counter resets.

Optional Feature:
- Macro: CLK_MEAS_DUTY_CALC_EN.
- Defined:
  - Closing `rise` loads the divider: numerator high*100, denominator period.
  - A restoring divider produces 7 quotient bits, one per cycle.
  - meas_valid pulses 8 cycles after the closing `rise` (1 load + 7 iterations). All three result outputs update together.
  - If another closing `rise` arrives while the divider is busy (period < 8), the new result is dropped and overrun pulses. The in-flight result still completes.
- Undefined:
  - No divider; duty_pct tied 0.
  - meas_valid pulses 1 cycle after the closing `rise`.
  - overrun never asserts.

Decomposition:
- Package clk_meas_pkg:
  - state enum {IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW}.
  - DUTY_W=7.
  - PCT_SCALE=100.
  - DIV_LAT=8.
- Sub-module clk_meas_div: iterative restoring divider with start/done handshake. Instantiated only under CLK_MEAS_DUTY_CALC_EN.

Test Plan:
- 100MHz clk, sig 10MHz 30% duty (H=3, L=7), en=1 -> from second rise onward every period: period_cnt=10, high_cnt=3, duty_pct=30 (feature on).
- sig 1MHz 50% -> period_cnt=100, high_cnt=50, duty_pct=50. meas_valid exactly 8 cycles (feature on) or 1 cycle (off) after the synced rise.
- sig held 0 after en -> timeout=1 after 1000 cycles, busy=1, no meas_valid. Deassert en -> timeout=0, busy=0 next cycle.
- Feature on, sig H=2, L=3 (period 5) -> alternate results dropped with overrun pulses. Reported values period_cnt=5, high_cnt=2, duty_pct=40.
- Mid-MEAS_LOW en=0 -> no meas_valid, outputs keep previous result.
- Mid-MEAS_LOW rst=1 -> all outputs 0 asynchronously.
- Re-enable -> first result only after a full new period.
